// File: rtl/minisys_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, data width.
package minisys_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating count of DMA requests lost to the CPU; raises force_dma at LIMIT.
module dmem_arb_starve
    import minisys_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic force_dma
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != 8'(LIMIT))) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_dma = (cnt_q == 8'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto one data-memory port, one access in flight.
// Define DMEM_ARB_STARVE_GUARD_EN to let a starved DMA port pre-empt the CPU.
module dmem_arbiter
    import minisys_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        wait_q, wait_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic arb;
    logic grant_dma;
    logic go_ack;
    logic force_dma;

    assign arb       = (state_q == IDLE) && (cpu_req || dma_req);
    assign grant_dma = dma_req && (!cpu_req || force_dma);
    assign go_ack    = ((state_q == ISSUE) && (RD_LAT == 1)) ||
                       ((state_q == WAIT) && (wait_q == 3'd0));

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic starve_inc;
    logic starve_clr;

    assign starve_inc = arb && !grant_dma && dma_req;
    assign starve_clr = arb && grant_dma;

    dmem_arb_starve #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .force_dma(force_dma)
    );
`else
    assign force_dma = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (arb) begin
                    owner_d     = grant_dma ? OWN_DMA : OWN_CPU;
                    we_d        = grant_dma ? dma_we : cpu_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    mem_addr_d  = grant_dma ? dma_addr : cpu_addr;
                    mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = WAIT_INIT;
                state_d = (RD_LAT == 1) ? ACK : WAIT;
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = ACK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase

        // Read data is captured on the edge that enters ACK.
        if (go_ack) begin
            if (owner_q == OWN_CPU) begin
                cpu_ack_d = 1'b1;
                if (!we_q) cpu_rdata_d = mem_rdata;
            end else begin
                dma_ack_d = 1'b1;
                if (!we_q) dma_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            wait_q      <= '0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req && !cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: u_a runs RD_LAT=1/STARVE_LIMIT=2, u_b runs RD_LAT=3.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cmp = 0;
    int   err = 0;

    always #5 clk = ~clk;

    logic        a_cpu_req, a_cpu_we, a_cpu_ack, a_cpu_stall;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic        a_dma_req, a_dma_we, a_dma_ack;
    logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_cpu_stall;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic        b_dma_req, b_dma_we, b_dma_ack;
    logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .RD_LAT(1), .STARVE_LIMIT(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we),
        .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .cpu_stall(a_cpu_stall),
        .dma_req(a_dma_req), .dma_we(a_dma_we),
        .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
        .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .RD_LAT(3), .STARVE_LIMIT(8)) u_b (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we),
        .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .cpu_stall(b_cpu_stall),
        .dma_req(b_dma_req), .dma_we(b_dma_we),
        .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // Memories: data is valid RD_LAT edges after mem_en rises, garbage before.
    logic [31:0] a_mem [0:63] = '{4: 32'hDEADBEEF, 8: 32'hCAFEF00D, default: 32'h0};
    logic [31:0] b_mem [0:63] = '{17: 32'h55AA55AA, default: 32'h0};
    logic [2:0]  b_age = 3'd0;

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) a_mem[a_mem_addr[7:2]] <= a_mem_wdata;
        if (b_mem_en && b_mem_we) b_mem[b_mem_addr[7:2]] <= b_mem_wdata;
        if (b_mem_en) b_age <= 3'd1;
        else if (b_age != 3'd0 && b_age != 3'd7) b_age <= b_age + 3'd1;
    end

    assign a_mem_rdata = a_mem_en ? a_mem[a_mem_addr[7:2]] : 32'hBAD0BAD0;
    assign b_mem_rdata = (!b_mem_en && b_age >= 3'd2) ?
                         b_mem[b_mem_addr[7:2]] : 32'hBAD0BAD0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        {a_cpu_req, a_cpu_we, a_dma_req, a_dma_we} = '0;
        {b_cpu_req, b_cpu_we, b_dma_req, b_dma_we} = '0;
        a_cpu_addr = '0; a_cpu_wdata = '0; a_dma_addr = '0; a_dma_wdata = '0;
        b_cpu_addr = '0; b_cpu_wdata = '0; b_dma_addr = '0; b_dma_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp++;
        if ({a_mem_en, a_mem_we, a_cpu_ack, a_dma_ack, a_cpu_stall} !== 5'b0) begin
            err++;
            $display("FAIL reset_a_ctl: got %b want 00000",
                     {a_mem_en, a_mem_we, a_cpu_ack, a_dma_ack, a_cpu_stall});
        end
        cmp++;
        if ({a_mem_addr, a_mem_wdata, a_cpu_rdata, a_dma_rdata} !== 128'h0) begin
            err++;
            $display("FAIL reset_a_data: got %h want 0",
                     {a_mem_addr, a_mem_wdata, a_cpu_rdata, a_dma_rdata});
        end
        cmp++;
        if ({b_mem_en, b_mem_we, b_cpu_ack, b_dma_ack, b_mem_addr, b_cpu_rdata} !== 68'h0) begin
            err++;
            $display("FAIL reset_b: got %h want 0",
                     {b_mem_en, b_mem_we, b_cpu_ack, b_dma_ack, b_mem_addr, b_cpu_rdata});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h10;
        @(negedge clk);
        cmp++;
        if ({a_cpu_stall, a_mem_en} !== 2'b10) begin
            err++;
            $display("FAIL rd_n_stall_en: got %b want 10", {a_cpu_stall, a_mem_en});
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({a_mem_en, a_mem_we, a_cpu_ack, a_mem_addr} !== {3'b100, 32'h10}) begin
            err++;
            $display("FAIL rd_issue: got %h want 4_00000010",
                     {a_mem_en, a_mem_we, a_cpu_ack, a_mem_addr});
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({a_cpu_ack, a_cpu_stall, a_dma_ack} !== 3'b100) begin
            err++;
            $display("FAIL rd_ack: got %b want 100", {a_cpu_ack, a_cpu_stall, a_dma_ack});
        end
        cmp++;
        if (a_cpu_rdata !== 32'hDEADBEEF) begin
            err++;
            $display("FAIL rd_data: got %h want deadbeef", a_cpu_rdata);
        end
        tick();
        a_cpu_req = 1'b0;
        @(negedge clk);
        cmp++;
        if ({a_cpu_ack, a_mem_en, a_mem_addr, a_cpu_rdata} !== {2'b00, 32'h10, 32'hDEADBEEF}) begin
            err++;
            $display("FAIL rd_hold: got %h want 0_00000010_deadbeef",
                     {a_cpu_ack, a_mem_en, a_mem_addr, a_cpu_rdata});
        end
        tick();
    endtask

    task automatic test_simultaneous;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h10;
        a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 32'h20;
        tick();
        @(negedge clk);
        cmp++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h10}) begin
            err++;
            $display("FAIL sim_cpu_first: got %h want 1_00000010", {a_mem_en, a_mem_addr});
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({a_cpu_ack, a_dma_ack} !== 2'b10) begin
            err++;
            $display("FAIL sim_cpu_ack: got %b want 10", {a_cpu_ack, a_dma_ack});
        end
        tick();
        a_cpu_req = 1'b0;
        @(negedge clk);
        cmp++;
        if ({a_cpu_ack, a_dma_ack, a_mem_en} !== 3'b000) begin
            err++;
            $display("FAIL sim_gap: got %b want 000", {a_cpu_ack, a_dma_ack, a_mem_en});
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h20}) begin
            err++;
            $display("FAIL sim_dma_issue: got %h want 1_00000020", {a_mem_en, a_mem_addr});
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({a_dma_ack, a_cpu_ack, a_dma_rdata, a_cpu_rdata} !==
            {2'b10, 32'hCAFEF00D, 32'hDEADBEEF}) begin
            err++;
            $display("FAIL sim_dma_ack: got %h want 2_cafef00d_deadbeef",
                     {a_dma_ack, a_cpu_ack, a_dma_rdata, a_cpu_rdata});
        end
        tick();
        a_dma_req = 1'b0;
        tick();
    endtask

    task automatic test_starve;
        logic exp_c, exp_d, exp_s;
        a_cpu_we = 1'b0; a_cpu_addr = 32'h10;
        a_dma_we = 1'b0; a_dma_addr = 32'h20;
        for (int c = 0; c < 15; c++) begin
            a_cpu_req = (c <= 11);
`ifdef DMEM_ARB_STARVE_GUARD_EN
            a_dma_req = (c <= 8);
            exp_c = (c == 2) || (c == 5) || (c == 11);
            exp_d = (c == 8);
`else
            a_dma_req = 1'b1;
            exp_c = (c % 3 == 2) && (c <= 11);
            exp_d = (c == 14);
`endif
            exp_s = (c <= 11) && !exp_c;
            @(negedge clk);
            cmp++;
            if ({a_cpu_ack, a_dma_ack, a_cpu_stall} !== {exp_c, exp_d, exp_s}) begin
                err++;
                $display("FAIL starve_c%0d: got ack/ack/stall %b want %b",
                         c, {a_cpu_ack, a_dma_ack, a_cpu_stall}, {exp_c, exp_d, exp_s});
            end
`ifdef DMEM_ARB_STARVE_GUARD_EN
            if (c == 4 || c == 7) begin
                cmp++;
                if (u_a.u_starve.cnt_q !== ((c == 4) ? 8'd2 : 8'd0)) begin
                    err++;
                    $display("FAIL starve_cnt_c%0d: got %0d want %0d",
                             c, u_a.u_starve.cnt_q, (c == 4) ? 2 : 0);
                end
            end
`endif
            tick();
        end
        a_cpu_req = 1'b0;
        a_dma_req = 1'b0;
        tick();
    endtask

    task automatic test_dma_write_cpu_read;
        b_dma_req = 1'b1; b_dma_we = 1'b1; b_dma_addr = 32'h40; b_dma_wdata = 32'h1234;
        tick();
        @(negedge clk);
        cmp++;
        if ({b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata} !== {2'b11, 32'h40, 32'h1234}) begin
            err++;
            $display("FAIL wr_issue: got %h want 3_00000040_00001234",
                     {b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata});
        end
        tick();
        tick();
        @(negedge clk);
        cmp++;
        if ({b_dma_ack, b_mem_en, b_mem_we} !== 3'b000) begin
            err++;
            $display("FAIL wr_wait: got %b want 000", {b_dma_ack, b_mem_en, b_mem_we});
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({b_dma_ack, b_dma_rdata} !== {1'b1, 32'h0}) begin
            err++;
            $display("FAIL wr_ack: got %h want 1_00000000", {b_dma_ack, b_dma_rdata});
        end
        tick();
        b_dma_req = 1'b0; b_dma_we = 1'b0;
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h40;
        tick();
        @(negedge clk);
        cmp++;
        if ({b_mem_en, b_mem_we} !== 2'b10) begin
            err++;
            $display("FAIL rd3_issue: got %b want 10", {b_mem_en, b_mem_we});
        end
        tick();
        tick();
        @(negedge clk);
        cmp++;
        if (b_cpu_ack !== 1'b0) begin
            err++;
            $display("FAIL rd3_early: got %b want 0", b_cpu_ack);
        end
        tick();
        @(negedge clk);
        cmp++;
        if ({b_cpu_ack, b_dma_ack, b_cpu_rdata} !== {2'b10, 32'h1234}) begin
            err++;
            $display("FAIL rd3_ack: got %h want 2_00001234",
                     {b_cpu_ack, b_dma_ack, b_cpu_rdata});
        end
        tick();
        b_cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h44;
        tick();
        tick();
        rst_n = 1'b0;
        b_cpu_req = 1'b0;
        #1;
        cmp++;
        if ({b_mem_en, b_mem_we, b_cpu_ack, b_dma_ack, b_cpu_stall,
             b_mem_addr, b_mem_wdata, b_cpu_rdata, b_dma_rdata} !== 133'h0) begin
            err++;
            $display("FAIL rstmid_b: got %h want 0",
                     {b_mem_en, b_mem_we, b_cpu_ack, b_dma_ack, b_cpu_stall,
                      b_mem_addr, b_mem_wdata, b_cpu_rdata, b_dma_rdata});
        end
        cmp++;
        if ({a_cpu_rdata, a_dma_rdata} !== 64'h0) begin
            err++;
            $display("FAIL rstmid_a: got %h want 0", {a_cpu_rdata, a_dma_rdata});
        end
        repeat (2) begin
            @(negedge clk);
            cmp++;
            if ({b_cpu_ack, b_dma_ack} !== 2'b00) begin
                err++;
                $display("FAIL rstmid_noack: got %b want 00", {b_cpu_ack, b_dma_ack});
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_cpu_req = 1'b1; b_cpu_addr = 32'h44;
        tick();
        @(negedge clk);
        cmp++;
        if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h44}) begin
            err++;
            $display("FAIL rstmid_issue: got %h want 1_00000044", {b_mem_en, b_mem_addr});
        end
        repeat (3) tick();
        @(negedge clk);
        cmp++;
        if ({b_cpu_ack, b_cpu_rdata} !== {1'b1, 32'h55AA55AA}) begin
            err++;
            $display("FAIL rstmid_ack: got %h want 1_55aa55aa", {b_cpu_ack, b_cpu_rdata});
        end
        tick();
        b_cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_starve();
        test_dma_write_cpu_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
